// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: register address and data widths, writeback source select, buffer entry.
// Latency: none (types and constants only).
// Backpressure: none.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LNG
  } wb_src_e;

  // One buffered long-latency result: destination register and value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_ent_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO holding long-latency writeback results until the regfile port is free.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller only pushes below DEPTH and only pops when nonempty.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output logic [W-1:0]           head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and buffered long-latency results onto one regfile port.
// Latency: one cycle from selection to o_rd_*; scoreboard query is combinational.
// Backpressure: o_lng_ready drops when the buffer is full; o_alu_hold asks upstream to skip the ALU next cycle.
module wb_arbiter
  import riscv_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int AGE_MAX = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_alu_valid,
  input  logic [REG_ADDR_W-1:0] i_alu_rd,
  input  logic [XLEN-1:0]       i_alu_data,
  input  logic                  i_lng_valid,
  input  logic [REG_ADDR_W-1:0] i_lng_rd,
  input  logic [XLEN-1:0]       i_lng_data,
  output logic                  o_lng_ready,
  input  logic                  i_iss_valid,
  input  logic [REG_ADDR_W-1:0] i_iss_rd,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  output logic                  o_rs1_pend,
  output logic                  o_rs2_pend,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic [XLEN-1:0]       o_rd_data,
  output logic                  o_rd_wren,
  output logic                  o_alu_hold
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(AGE_MAX + 1);

  logic [CW-1:0] count;
  wb_ent_t       head;
  wb_ent_t       push_ent;
  logic          nonempty;
  logic          push;
  logic          pop;
  wb_src_e       sel;
  logic [AW-1:0] age;
  logic [AW-1:0] age_inc;
  logic [31:0]   pend;
  logic [31:0]   pend_set;
  logic [31:0]   pend_clr;
  logic [31:0]   pend_nxt;

  assign nonempty    = (count != '0);
  assign o_lng_ready = (count < CW'(DEPTH));
  assign push        = i_lng_valid && o_lng_ready && (i_lng_rd != '0) && !i_rst;
  assign pop         = (sel == WB_LNG) && !i_rst;
  assign push_ent    = '{rd: i_lng_rd, data: i_lng_data};
  assign age_inc     = (age == AW'(AGE_MAX)) ? age : age + 1'b1;

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(wb_ent_t))
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (push),
    .push_data (push_ent),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  // Source select: an aged head under hold beats the ALU, otherwise the ALU has priority.
  always_comb begin
    sel = WB_NONE;
    if (o_alu_hold && nonempty) begin
      sel = WB_LNG;
    end else if (i_alu_valid && (i_alu_rd != '0)) begin
      sel = WB_ALU;
    end else if (nonempty) begin
      sel = WB_LNG;
    end
  end

  // Scoreboard next value: a new issue to rd overrides the clear from its own writeback.
  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (sel == WB_LNG) pend_clr[head.rd] = 1'b1;
    if (i_iss_valid && (i_iss_rd != '0)) pend_set[i_iss_rd] = 1'b1;
    pend_nxt    = (pend & ~pend_clr) | pend_set;
    pend_nxt[0] = 1'b0;
  end

  // Regfile write port; address and data hold when nothing is selected.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_wren <= 1'b0;
      o_rd_addr <= '0;
      o_rd_data <= '0;
    end else begin
      o_rd_wren <= (sel != WB_NONE);
      if (sel == WB_ALU) begin
        o_rd_addr <= i_alu_rd;
        o_rd_data <= i_alu_data;
      end else if (sel == WB_LNG) begin
        o_rd_addr <= head.rd;
        o_rd_data <= head.data;
      end
    end
  end

  // Head age and starvation hold: hold rises once the head has waited AGE_MAX-1 cycles, drops on its pop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      age        <= '0;
      o_alu_hold <= 1'b0;
    end else if (pop) begin
      age        <= '0;
      o_alu_hold <= 1'b0;
    end else if (nonempty) begin
      age <= age_inc;
      if (age_inc >= AW'(AGE_MAX - 1)) o_alu_hold <= 1'b1;
    end else begin
      age <= '0;
    end
  end

  // Pending-write scoreboard register.
  always_ff @(posedge i_clk) begin
    if (i_rst) pend <= '0;
    else       pend <= pend_nxt;
  end

  assign o_rs1_pend = pend[i_rs1_addr];
  assign o_rs2_pend = pend[i_rs2_addr];

endmodule
